// File: rtl/i2c_byte_sequencer.sv
// i2c_byte_sequencer
// Byte-level I2C master sequencer. Generates SCL timing, START/RESTART,
// STOP, 8 data bits and the ACK bit. It drives an external 8-bit SDA shift
// register through its load, shift-enable and parallel-data interface.
// Optional macro I2C_STRETCH_EN: when defined, the quarter counter holds
// while the synchronized SCL is low during the SCL-high quarter, which
// supports slave clock stretching.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready=1
// S_START | START/RESTART: SDA falls while SCL is high, then SCL is held low
// S_LOAD  | one-cycle parallel load of the shift register
// S_BIT   | 8 data bits, 4 quarters each, MSB first
// S_ACK   | ninth bit: the master samples ACK (WRITE) or drives it (READ)
// S_STOP  | STOP: SDA rises while SCL is high
// S_DONE  | one-cycle done pulse, rx_byte captured
module i2c_byte_sequencer #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_byte,
    input  logic       cmd_nack,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       ack_out,
    output logic       arb_lost,
    output logic       busy,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       sr_load,
    output logic       sr_shift_en,
    output logic [7:0] sr_data,
    input  logic [7:0] sr_q
);

    localparam int QW = $clog2(CLK_DIV);
    localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

`ifdef I2C_STRETCH_EN
    localparam logic P_STRETCH = 1'b1;
`else
    localparam logic P_STRETCH = 1'b0;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_BIT   = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    logic [2:0]    r_state;
    logic [QW-1:0] r_qcnt;
    logic [1:0]    r_q;
    logic [2:0]    r_bitcnt;
    logic [1:0]    r_cmd;
    logic          r_nack;
    logic          r_scl_s1, r_scl_s2;
    logic          r_sda_s1, r_sda_s2;
    logic          r_done;
    logic [7:0]    r_rx_byte;
    logic          r_ack_out;
    logic          r_arb_lost;
    logic          r_scl_oe;
    logic          r_sda_oe;
    logic          r_sr_load;
    logic          r_sr_shift_en;
    logic [7:0]    r_sr_data;

    logic w_scl_s;
    logic w_sda_s;
    logic w_active;
    logic w_entry;
    logic w_stretch_q;
    logic w_stall;
    logic w_qend;
    logic w_last_q;
    logic w_is_write;
    logic w_arb;

    assign w_scl_s     = r_scl_s2;
    assign w_sda_s     = r_sda_s2;
    assign w_active    = (r_state == S_START) || (r_state == S_BIT) ||
                         (r_state == S_ACK)   || (r_state == S_STOP);
    // First cycle of a quarter; quarter actions are decided here and seen one cycle later.
    assign w_entry     = (r_qcnt == '0);
    assign w_stretch_q = (((r_state == S_BIT) || (r_state == S_ACK)) && (r_q == 2'd2)) ||
                         (((r_state == S_START) || (r_state == S_STOP)) && (r_q == 2'd1));
    assign w_stall     = P_STRETCH & w_stretch_q & ~w_scl_s;
    assign w_qend      = w_active & ~w_stall & (r_qcnt == QLAST);
    assign w_last_q    = w_qend & (r_q == 2'd3);
    assign w_is_write  = (r_cmd == CMD_WRITE);
    // Another master is pulling SDA low while we released it for a 1 bit.
    assign w_arb       = (r_state == S_BIT) && (r_q == 2'd3) && w_entry &&
                         w_is_write && !r_sda_oe && !w_sda_s;

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = ~cmd_ready;
    assign done        = r_done;
    assign rx_byte     = r_rx_byte;
    assign ack_out     = r_ack_out;
    assign arb_lost    = r_arb_lost;
    assign scl_oe      = r_scl_oe;
    assign sda_oe      = r_sda_oe;
    assign sr_load     = r_sr_load;
    assign sr_shift_en = r_sr_shift_en;
    assign sr_data     = r_sr_data;

    // Two-flop synchronizers for the raw pad inputs (idle bus reads high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
        end
    end

    // Quarter counter and quarter index; cleared outside the timed states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qcnt <= '0;
            r_q    <= 2'd0;
        end else if (!w_active) begin
            r_qcnt <= '0;
            r_q    <= 2'd0;
        end else if (!w_stall) begin
            if (r_qcnt == QLAST) begin
                r_qcnt <= '0;
                r_q    <= r_q + 2'd1;
            end else begin
                r_qcnt <= r_qcnt + QW'(1);
            end
        end
    end

    // Sequencer FSM with registered pad enables and shift-register strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_bitcnt      <= 3'd0;
            r_cmd         <= 2'b00;
            r_nack        <= 1'b0;
            r_done        <= 1'b0;
            r_rx_byte     <= 8'h00;
            r_ack_out     <= 1'b0;
            r_arb_lost    <= 1'b0;
            r_scl_oe      <= 1'b0;
            r_sda_oe      <= 1'b0;
            r_sr_load     <= 1'b0;
            r_sr_shift_en <= 1'b0;
            r_sr_data     <= 8'h00;
        end else begin
            r_done        <= 1'b0;
            r_sr_load     <= 1'b0;
            r_sr_shift_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd      <= cmd;
                        r_nack     <= cmd_nack;
                        r_arb_lost <= 1'b0;
                        if (cmd == CMD_START) begin
                            r_state <= S_START;
                        end else if (cmd == CMD_STOP) begin
                            r_state <= S_STOP;
                        end else begin
                            r_state   <= S_LOAD;
                            r_sr_load <= 1'b1;
                            r_sr_data <= (cmd == CMD_WRITE) ? tx_byte : 8'hFF;
                        end
                    end
                end
                S_START: begin
                    if (w_entry) begin
                        case (r_q)
                            2'd0:    r_sda_oe <= 1'b0;
                            2'd1:    r_scl_oe <= 1'b0;
                            2'd2:    r_sda_oe <= 1'b1;
                            default: r_scl_oe <= 1'b1;
                        endcase
                    end
                    if (w_last_q) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_rx_byte <= sr_q;
                    end
                end
                S_LOAD: begin
                    r_state  <= S_BIT;
                    r_bitcnt <= 3'd0;
                end
                S_BIT: begin
                    if (w_arb) begin
                        r_arb_lost <= 1'b1;
                        r_ack_out  <= 1'b1;
                        r_scl_oe   <= 1'b0;
                        r_sda_oe   <= 1'b0;
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_rx_byte  <= sr_q;
                    end else begin
                        if (w_entry) begin
                            case (r_q)
                                2'd0: begin
                                    r_scl_oe <= 1'b1;
                                    r_sda_oe <= w_is_write ? ~sr_q[7] : 1'b0;
                                end
                                2'd2:    r_scl_oe      <= 1'b0;
                                2'd3:    r_sr_shift_en <= 1'b1;
                                default: ;
                            endcase
                        end
                        if (w_last_q) begin
                            if (r_bitcnt == 3'd7) begin
                                r_state <= S_ACK;
                            end else begin
                                r_bitcnt <= r_bitcnt + 3'd1;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (w_entry) begin
                        case (r_q)
                            2'd0: begin
                                r_scl_oe <= 1'b1;
                                r_sda_oe <= w_is_write ? 1'b0 : ~r_nack;
                            end
                            2'd2: r_scl_oe <= 1'b0;
                            2'd3: begin
                                if (w_is_write) begin
                                    r_ack_out <= w_sda_s;
                                end
                            end
                            default: ;
                        endcase
                    end
                    if (w_last_q) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_rx_byte <= sr_q;
                        r_scl_oe  <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_entry) begin
                        case (r_q)
                            2'd0: begin
                                r_scl_oe <= 1'b1;
                                r_sda_oe <= 1'b1;
                            end
                            2'd1:    r_scl_oe <= 1'b0;
                            2'd3:    r_sda_oe <= 1'b0;
                            default: ;
                        endcase
                    end
                    if (w_last_q) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_rx_byte <= sr_q;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
